// File: rtl/sram_arb.sv
// Round-robin arbiter sharing one single-port SRAM (read latency LC) between two Avalon-MM masters.
// Optional feature: define SRAM_ARB_LOCK_EN to add m0_lock/m1_lock grant locking.
module sram_arb #(
   parameter int AW = 5,
   parameter int DW = 32,
   parameter int LC = 1
) (
   input  logic              clk,
   input  logic              reset,
`ifdef SRAM_ARB_LOCK_EN
   input  logic              m0_lock,
   input  logic              m1_lock,
`endif
   input  logic [AW-1:0]     m0_address,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DW/8-1:0]   m0_byteenable,
   input  logic [DW-1:0]     m0_writedata,
   output logic              m0_waitrequest,
   output logic [DW-1:0]     m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [AW-1:0]     m1_address,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DW/8-1:0]   m1_byteenable,
   input  logic [DW-1:0]     m1_writedata,
   output logic              m1_waitrequest,
   output logic [DW-1:0]     m1_readdata,
   output logic              m1_readdatavalid,
   output logic              sram_cs,
   output logic [DW/8-1:0]   sram_we,
   output logic [AW-1:0]     sram_addr,
   output logic [DW-1:0]     sram_wdata,
   input  logic [DW-1:0]     sram_rdata
);

   localparam int BW = DW / 8;

   logic          req0, req1;
   logic          keep0, keep1;
   logic          gnt0, gnt1;
   logic          last_grant;
   logic          acc, acc_wr, acc_rd;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr, addr_q;
   logic [DW-1:0] cmd_wdata, wdata_q;
   logic [BW-1:0] cmd_be;
   logic          rsp_valid, rsp_owner;

   // Grant is purely combinational so the command reaches the SRAM in the request cycle.
   always_comb begin
      req0  = m0_read | m0_write;
      req1  = m1_read | m1_write;
`ifdef SRAM_ARB_LOCK_EN
      keep0 = ~last_grant & m0_lock & req0;
      keep1 =  last_grant & m1_lock & req1;
`else
      keep0 = 1'b0;
      keep1 = 1'b0;
`endif
      gnt0  = 1'b0;
      gnt1  = 1'b0;
      if (!reset) begin
         if (keep0)
            gnt0 = 1'b1;
         else if (keep1)
            gnt1 = 1'b1;
         else if (req0 && req1) begin
            gnt0 = last_grant;
            gnt1 = ~last_grant;
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
   end

   always_comb begin
      cmd_write = gnt1 ? m1_write      : m0_write;
      cmd_addr  = gnt1 ? m1_address    : m0_address;
      cmd_wdata = gnt1 ? m1_writedata  : m0_writedata;
      cmd_be    = gnt1 ? m1_byteenable : m0_byteenable;
      acc       = gnt0 | gnt1;
      acc_wr    = acc & cmd_write;
      acc_rd    = acc & ~cmd_write;
   end

   // A write with no byte lanes is still accepted but never selects the macro.
   assign sram_cs    = acc_rd | (acc_wr & (|cmd_be));
   assign sram_we    = acc_wr ? cmd_be : '0;
   assign sram_addr  = acc ? cmd_addr : addr_q;
   assign sram_wdata = acc_wr ? cmd_wdata : wdata_q;

   assign m0_waitrequest = reset | (req0 & ~gnt0);
   assign m1_waitrequest = reset | (req1 & ~gnt1);

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= 1'b1;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         if (acc) begin
            last_grant <= gnt1;
            addr_q     <= cmd_addr;
         end
         if (acc_wr)
            wdata_q <= cmd_wdata;
      end
   end

   generate
      if (LC == 0) begin : g_rsp_comb
         assign rsp_valid = acc_rd;
         assign rsp_owner = gnt1;
      end else begin : g_rsp_pipe
         logic [LC-1:0] pipe_valid;
         logic [LC-1:0] pipe_owner;

         always_ff @(posedge clk) begin
            if (reset) begin
               pipe_valid <= '0;
               pipe_owner <= '0;
            end else begin
               pipe_valid[0] <= acc_rd;
               pipe_owner[0] <= gnt1;
               for (int i = 1; i < LC; i++) begin
                  pipe_valid[i] <= pipe_valid[i-1];
                  pipe_owner[i] <= pipe_owner[i-1];
               end
            end
         end

         assign rsp_valid = pipe_valid[LC-1] & ~reset;
         assign rsp_owner = pipe_owner[LC-1];
      end
   endgenerate

   assign m0_readdatavalid = rsp_valid & ~rsp_owner;
   assign m1_readdatavalid = rsp_valid &  rsp_owner;
   assign m0_readdata      = sram_rdata;
   assign m1_readdata      = sram_rdata;

endmodule

// File: tb/tb_sram_arb.sv
// Scoreboard bench for sram_arb: behavioural SRAM model plus expected-response queue.
// Lock scenario is built only when SRAM_ARB_LOCK_EN is defined.
module tb_sram_arb;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int LC = 2;

   typedef struct {
      logic        owner;
      logic [31:0] data;
      int          due;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
`ifdef SRAM_ARB_LOCK_EN
   logic          m0_lock, m1_lock;
`endif
   logic [AW-1:0] m0_address, m1_address;
   logic          m0_read, m0_write, m1_read, m1_write;
   logic [3:0]    m0_byteenable, m1_byteenable;
   logic [DW-1:0] m0_writedata, m1_writedata;
   logic          m0_waitrequest, m1_waitrequest;
   logic [DW-1:0] m0_readdata, m1_readdata;
   logic          m0_readdatavalid, m1_readdatavalid;
   logic          sram_cs;
   logic [3:0]    sram_we;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_wdata;
   logic [DW-1:0] sram_rdata;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   logic [DW-1:0] mem     [0:(1<<AW)-1];
   logic [DW-1:0] rd_pipe [0:LC-1];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sram_arb #(.AW(AW), .DW(DW), .LC(LC)) u_dut (
      .clk              (clk),
      .reset            (reset),
`ifdef SRAM_ARB_LOCK_EN
      .m0_lock          (m0_lock),
      .m1_lock          (m1_lock),
`endif
      .m0_address       (m0_address),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_byteenable    (m0_byteenable),
      .m0_writedata     (m0_writedata),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdata      (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .m1_address       (m1_address),
      .m1_read          (m1_read),
      .m1_write         (m1_write),
      .m1_byteenable    (m1_byteenable),
      .m1_writedata     (m1_writedata),
      .m1_waitrequest   (m1_waitrequest),
      .m1_readdata      (m1_readdata),
      .m1_readdatavalid (m1_readdatavalid),
      .sram_cs          (sram_cs),
      .sram_we          (sram_we),
      .sram_addr        (sram_addr),
      .sram_wdata       (sram_wdata),
      .sram_rdata       (sram_rdata)
   );

   // SRAM macro model: byte-lane writes, read data valid LC cycles after the command.
   always @(posedge clk) begin
      if (sram_cs) begin
         if (sram_we == 4'h0)
            rd_pipe[0] <= mem[sram_addr];
         else
            for (int b = 0; b < 4; b++)
               if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
      for (int i = 1; i < LC; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign sram_rdata = rd_pipe[LC-1];

   // Response monitor: every readdatavalid pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (m0_readdatavalid || m1_readdatavalid) begin
         n_tests++;
         if (m0_readdatavalid && m1_readdatavalid) begin
            n_fail++;
            $display("FAIL rsp_both: both readdatavalid high at cycle %0d", cyc);
         end else if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rsp_unexpected: m0_rdv=%0b m1_rdv=%0b at cycle %0d, none expected",
                     m0_readdatavalid, m1_readdatavalid, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            if (m1_readdatavalid !== mon_e.owner) begin
               n_fail++;
               $display("FAIL rsp_owner: got m%0d want m%0d", m1_readdatavalid, mon_e.owner);
            end
            n_tests++;
            if (cyc !== mon_e.due) begin
               n_fail++;
               $display("FAIL rsp_cycle: got %0d want %0d", cyc, mon_e.due);
            end
            n_tests++;
            if ((m1_readdatavalid ? m1_readdata : m0_readdata) !== mon_e.data) begin
               n_fail++;
               $display("FAIL rsp_data: got %h want %h",
                        m1_readdatavalid ? m1_readdata : m0_readdata, mon_e.data);
            end
         end
      end
   end

   function automatic void exp_push(input logic owner, input logic [31:0] data);
      exp_t e;
      e.owner = owner;
      e.data  = data;
      e.due   = cyc + LC;
      exp_q.push_back(e);
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < LC + 8 && exp_q.size() != 0; i++) next_cycle();
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: %0d responses missing, want 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic do_reset();
      idle_all();
      reset = 1;
      next_cycle();
      next_cycle();
      reset = 0;
   endtask

   task automatic test_reset();
      m0_read = 1; m0_address = 5'd7;
      m1_write = 1; m1_address = 5'd9; m1_byteenable = 4'hF; m1_writedata = 32'h12345678;
      @(negedge clk);
      n_tests++;
      if (m0_waitrequest !== 1 || m1_waitrequest !== 1) begin
         n_fail++;
         $display("FAIL reset_wait: got %0b/%0b want 1/1", m0_waitrequest, m1_waitrequest);
      end
      n_tests++;
      if (sram_cs !== 0 || sram_we !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_cs: got cs=%0b we=%h want 0/0", sram_cs, sram_we);
      end
      n_tests++;
      if (sram_addr !== 5'd0 || sram_wdata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_vals: got addr=%h wdata=%h want 0/0", sram_addr, sram_wdata);
      end
      n_tests++;
      if (m0_readdatavalid !== 0 || m1_readdatavalid !== 0) begin
         n_fail++;
         $display("FAIL reset_rdv: got %0b/%0b want 0/0", m0_readdatavalid, m1_readdatavalid);
      end
      idle_all();
      next_cycle();
      reset = 0;
      @(negedge clk);
      n_tests++;
      if (m0_waitrequest !== 0 || m1_waitrequest !== 0 || sram_cs !== 0) begin
         n_fail++;
         $display("FAIL idle_wait: got wait=%0b/%0b cs=%0b want 0/0/0",
                  m0_waitrequest, m1_waitrequest, sram_cs);
      end
      next_cycle();
   endtask

   task automatic test_write_read();
      m0_write = 1; m0_address = 5'd3; m0_byteenable = 4'hF; m0_writedata = 32'hDEADBEEF;
      @(negedge clk);
      n_tests++;
      if (m0_waitrequest !== 0 || sram_cs !== 1 || sram_we !== 4'hF || sram_addr !== 5'd3 ||
          sram_wdata !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL wr_cmd: got wait=%0b cs=%0b we=%h addr=%h wdata=%h want 0/1/f/03/deadbeef",
                  m0_waitrequest, sram_cs, sram_we, sram_addr, sram_wdata);
      end
      next_cycle();
      m0_write = 0; m0_read = 1;
      @(negedge clk);
      n_tests++;
      if (m0_waitrequest !== 0 || sram_cs !== 1 || sram_we !== 4'h0 || sram_addr !== 5'd3) begin
         n_fail++;
         $display("FAIL rd_cmd: got wait=%0b cs=%0b we=%h addr=%h want 0/1/0/03",
                  m0_waitrequest, sram_cs, sram_we, sram_addr);
      end
      exp_push(1'b0, 32'hDEADBEEF);
      next_cycle();
      m0_read = 0;
      @(negedge clk);
      n_tests++;
      if (sram_cs !== 0 || sram_we !== 4'h0 || sram_addr !== 5'd3 || sram_wdata !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL idle_hold: got cs=%0b we=%h addr=%h wdata=%h want 0/0/03/deadbeef",
                  sram_cs, sram_we, sram_addr, sram_wdata);
      end
      drain("write_read");
   endtask

   task automatic test_byte_lane();
      m0_write = 1; m0_address = 5'd5; m0_byteenable = 4'hF; m0_writedata = 32'h11223344;
      next_cycle();
      m0_byteenable = 4'h2; m0_writedata = 32'hAABBCCDD;
      next_cycle();
      m0_write = 0;
      m1_write = 1; m1_address = 5'd5; m1_byteenable = 4'h0; m1_writedata = 32'hFFFFFFFF;
      @(negedge clk);
      n_tests++;
      if (m1_waitrequest !== 0 || sram_cs !== 0 || sram_we !== 4'h0) begin
         n_fail++;
         $display("FAIL be0_write: got wait=%0b cs=%0b we=%h want 0/0/0",
                  m1_waitrequest, sram_cs, sram_we);
      end
      next_cycle();
      m1_write = 0;
      m0_read = 1;
      @(negedge clk);
      exp_push(1'b0, 32'h1122CC44);
      next_cycle();
      m0_read = 0;
      drain("byte_lane");
   endtask

   task automatic test_simultaneous();
      do_reset();
      m0_read = 1; m0_address = 5'd5;
      m1_read = 1; m1_address = 5'd3;
      @(negedge clk);
      n_tests++;
      if (m0_waitrequest !== 0 || m1_waitrequest !== 1 || sram_addr !== 5'd5) begin
         n_fail++;
         $display("FAIL sim_first: got wait=%0b/%0b addr=%h want 0/1/05",
                  m0_waitrequest, m1_waitrequest, sram_addr);
      end
      exp_push(1'b0, 32'h1122CC44);
      next_cycle();
      m0_read = 0;
      @(negedge clk);
      n_tests++;
      if (m1_waitrequest !== 0 || sram_addr !== 5'd3) begin
         n_fail++;
         $display("FAIL sim_second: got wait=%0b addr=%h want 0/03", m1_waitrequest, sram_addr);
      end
      exp_push(1'b1, 32'hDEADBEEF);
      next_cycle();
      m1_read = 0;
      drain("simultaneous");
   endtask

   task automatic test_round_robin();
      logic g;
      m0_read = 1; m0_address = 5'd5;
      m1_read = 1; m1_address = 5'd3;
      for (int i = 0; i < 6; i++) begin
         g = i[0];
         @(negedge clk);
         n_tests++;
         if (m0_waitrequest !== g || m1_waitrequest !== !g) begin
            n_fail++;
            $display("FAIL rr_grant%0d: got wait=%0b/%0b want %0b/%0b",
                     i, m0_waitrequest, m1_waitrequest, g, !g);
         end
         exp_push(g, g ? 32'hDEADBEEF : 32'h1122CC44);
         next_cycle();
      end
      idle_all();
      drain("round_robin");
   endtask

   task automatic test_back_to_back();
      m1_write = 1; m1_byteenable = 4'hF;
      for (int i = 0; i < 4; i++) begin
         m1_address = AW'(i);
         m1_writedata = 32'hB0B00000 + 32'(i);
         @(negedge clk);
         n_tests++;
         if (m1_waitrequest !== 0) begin
            n_fail++;
            $display("FAIL b2b_wr%0d: got wait=%0b want 0", i, m1_waitrequest);
         end
         next_cycle();
      end
      m1_write = 0; m1_read = 1;
      for (int i = 0; i < 4; i++) begin
         m1_address = AW'(i);
         @(negedge clk);
         n_tests++;
         if (m1_waitrequest !== 0 || sram_addr !== AW'(i)) begin
            n_fail++;
            $display("FAIL b2b_rd%0d: got wait=%0b addr=%h want 0/%h",
                     i, m1_waitrequest, sram_addr, AW'(i));
         end
         exp_push(1'b1, 32'hB0B00000 + 32'(i));
         next_cycle();
      end
      m1_read = 0;
      drain("back_to_back");
   endtask

   task automatic test_reset_midflight();
      m0_read = 1; m0_address = 5'd5;
      next_cycle();
      m0_read = 0;
      reset = 1;
      @(negedge clk);
      n_tests++;
      if (m0_readdatavalid !== 0 || m0_waitrequest !== 1 || m1_waitrequest !== 1) begin
         n_fail++;
         $display("FAIL mid_reset: got rdv=%0b wait=%0b/%0b want 0/1/1",
                  m0_readdatavalid, m0_waitrequest, m1_waitrequest);
      end
      next_cycle();
      reset = 0;
      for (int i = 0; i < LC + 2; i++) begin
         @(negedge clk);
         n_tests++;
         if (m0_readdatavalid !== 0 || m1_readdatavalid !== 0) begin
            n_fail++;
            $display("FAIL mid_flush%0d: got rdv=%0b/%0b want 0/0",
                     i, m0_readdatavalid, m1_readdatavalid);
         end
         next_cycle();
      end
      m1_read = 1; m1_address = 5'd0;
      @(negedge clk);
      exp_push(1'b1, 32'hB0B00000);
      next_cycle();
      m1_read = 0;
      drain("reset_midflight");
   endtask

`ifdef SRAM_ARB_LOCK_EN
   task automatic test_lock();
      do_reset();
      m0_lock = 1;
      m0_read = 1; m0_address = 5'd5;
      m1_read = 1; m1_address = 5'd3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_tests++;
         if (m0_waitrequest !== 0 || m1_waitrequest !== 1) begin
            n_fail++;
            $display("FAIL lock_hold%0d: got wait=%0b/%0b want 0/1", i, m0_waitrequest, m1_waitrequest);
         end
         exp_push(1'b0, 32'h1122CC44);
         next_cycle();
      end
      m0_lock = 0; m0_read = 0;
      @(negedge clk);
      n_tests++;
      if (m1_waitrequest !== 0) begin
         n_fail++;
         $display("FAIL lock_release: got wait=%0b want 0", m1_waitrequest);
      end
      exp_push(1'b1, 32'hB0B00003);
      next_cycle();
      m1_read = 0;
      drain("lock");
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
      for (int i = 0; i < LC; i++) rd_pipe[i] = '0;
      reset = 1;
`ifdef SRAM_ARB_LOCK_EN
      m0_lock = 0; m1_lock = 0;
`endif
      m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
      m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
      idle_all();
      next_cycle();
      test_reset();
      test_write_read();
      test_byte_lane();
      test_simultaneous();
      test_round_robin();
      test_back_to_back();
      test_reset_midflight();
`ifdef SRAM_ARB_LOCK_EN
      test_lock();
`endif
      repeat (4) next_cycle();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_arb.md
# sram_arb

Two-master Avalon-MM arbiter that shares one single-port SRAM macro with fixed read latency `LC` (0, 1 or 2 cycles). Each cycle it accepts at most one command, using round-robin between masters. It drives the SRAM chip-select, byte write enables, address and data, and returns read data to the master that issued the read. The block sits between two bus masters (e.g. CPU data port and DMA) and the shared `sram` instance.

## Interface
Parameters:
- `AW`, 5: SRAM word-address width; memory depth is 2^AW words.
- `DW`, 32: data width; must be a multiple of 8.
- `LC`, 1: SRAM read latency in cycles, from command to `sram_rdata` valid; legal values 0, 1, 2.

Ports (x = 0, 1):
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mx_address`  in  AW  word address.
- `mx_read`  in  1  read request.
- `mx_write`  in  1  write request.
- `mx_byteenable`  in  DW/8  byte lanes for a write.
- `mx_writedata`  in  DW  write data.
- `mx_waitrequest`  out  1  command not accepted this cycle.
- `mx_readdata`  out  DW  read data, qualified by `mx_readdatavalid`.
- `mx_readdatavalid`  out  1  one-cycle read-response strobe.
- `sram_cs`  out  1  SRAM chip select.
- `sram_we`  out  DW/8  byte write enables; all zero means read.
- `sram_addr`  out  AW  SRAM address.
- `sram_wdata`  out  DW  SRAM write data.
- `sram_rdata`  in  DW  SRAM read data, valid exactly LC cycles after a read command.

## Operation
- **Request:** a master requests when `mx_read` or `mx_write` is high.
- **Conflict resolution:** if both `mx_read` and `mx_write` are high, the request is a write.
- **Grant:** combinational and single-requester-or-round-robin.
  - One requester: that master is granted.
  - Both requesting: the master not recorded in `last_grant` is granted.
  - `last_grant` updates to the granted master on every accepted command.
- **Waitrequest:** `mx_waitrequest = request & ~grant_x`.
  - When idle, `mx_waitrequest` is 0.
  - During `reset`, `mx_waitrequest` is 1.
- **Accepted write:**
  - `sram_cs = 1`, `sram_we = byteenable`, address and data passed through.
  - Write with `byteenable == 0`: accepted, `sram_cs = 0`, no memory effect, no response.
- **Accepted read:**
  - `sram_cs = 1`, `sram_we = 0`.
  - A response tag {valid, owner} enters an LC-deep shift pipeline.
- **Response delivery:** when the pipeline tail is valid, `readdatavalid` pulses for the owner only.
  - Both `m0_readdata` and `m1_readdata` equal `sram_rdata` at all times.
  - LC = 0: the response is combinational in the acceptance cycle; there is no pipeline.
- **Pipelining:** reads are fully pipelined.
  - One read may be accepted every cycle regardless of outstanding reads.
  - Responses return in issue order.
  - Writes may be issued behind outstanding reads.
- **Idle cycle:** `sram_cs = 0`, `sram_we = 0`; `sram_addr` and `sram_wdata` hold their last values.
- **Reset (synchronous):**
  - Clears the response pipeline; in-flight reads produce no `readdatavalid`.
  - `last_grant` = 1, so m0 wins the first conflict.
  - Outputs during `reset`: `sram_cs = 0`, `sram_we = 0`, `readdatavalid = 0`, `waitrequest = 1`.
  - Output reset values: `sram_addr` = 0, `sram_wdata` = 0.

## Timing
- Grant and waitrequest are combinational from requests and `last_grant`; the command appears on the SRAM in the same cycle.
- A read accepted in cycle T produces `readdatavalid` in cycle T+LC.
- Throughput: one command per cycle. With both masters continuously requesting, grants alternate m0, m1, m0, …
- A waited master must hold its command stable. The worst-case wait is one cycle when the other master also requests.

## Configuration
- `SRAM_ARB_LOCK_EN` defined:
  - Adds input ports `m0_lock` and `m1_lock`.
  - While the current `last_grant` owner has its lock high and is requesting, it keeps the grant even if the other master requests.
  - When the owner deasserts lock or stops requesting, normal round-robin resumes.
- `SRAM_ARB_LOCK_EN` undefined: no lock ports; pure round-robin.

## Test plan
- **Single write then read:** m0 writes 0xDEADBEEF, byteenable 0xF, to address 3, then reads address 3 (LC = 1) -> `m0_readdatavalid` one cycle after the read is accepted, `m0_readdata` = 0xDEADBEEF, m1 sees no valid.
- **Simultaneous requests after reset:** m0 and m1 both read in the first cycle after reset -> m0 granted, m1 waitrequest = 1. Next cycle m1 is granted, and responses arrive in cycles T+LC and T+1+LC with the correct owners.
- **Back-to-back reads:** m1 reads addresses 0..3 with LC = 2 and continuous requests -> four consecutive `m1_readdatavalid` pulses starting 2 cycles after the first accept, data in address order.
- **Byte-lane write:** write 0x11223344 to address 5, then write 0xAABBCCDD with byteenable 0x2, then read -> 0x1122CC44.
- **Reset mid-flight:** `reset` asserted one cycle after a read is accepted with LC = 2 -> no `readdatavalid` appears; a read after reset releases normally.
- **Lock (SRAM_ARB_LOCK_EN):** m0 holds lock while issuing 3 reads and m1 requests throughout -> m1 waitrequest stays 1 until m0 drops lock, then m1 is granted next.
